sensor_avg_fsm: RTL and testbench
=================================

SENSOR_AVG_FSM -- requirements
Module: sensor_avg_fsm

Interface
REQ-001 SHALL have parameter DataWidth, default 8, width of one measurement byte; a sample is 2*DataWidth bits.
REQ-002 SHALL have parameter AvgLog2, default 2, log2 of samples averaged per measurement cycle; legal range 0..4.
REQ-003 SHALL have port Clk_i, input, 1, sole clock, rising edge.
REQ-004 SHALL have port Reset_n_i, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port Enable_i, input, 1, block enable.
REQ-006 SHALL have port CpuIntr_o, output, 1, one-cycle CPU notification pulse.
REQ-007 SHALL have port SensorValue_o, output, 2*DataWidth, last stored averaged value.
REQ-008 SHALL have port Busy_o, output, 1, high while in stXfer or stCompare.
REQ-009 SHALL have port MeasureFSM_Start_o, output, 1, one-cycle start pulse to the measurement FSM.
REQ-010 SHALL have port MeasureFSM_Done_i, input, 1, measurement complete, sampled only in stXfer.
REQ-011 SHALL have ports MeasureFSM_Byte0_i and MeasureFSM_Byte1_i, input, DataWidth each; sample = {Byte1, Byte0}, valid with Done.
REQ-012 SHALL have port ParamThreshold_i, input, 2*DataWidth, notification threshold.
REQ-013 SHALL have port ParamCounterPreset_i, input, 2*DataWidth, idle-timer preset.
REQ-014 SHALL have port Error_o, output, 1, sticky measurement-timeout flag.

Function
REQ-015 SHALL implement states stDisabled, stIdle, stXfer, stCompare, stNotify.
REQ-016 stDisabled: Enable_i=1 -> preset timer, clear accumulator and sample counter, go stIdle.
REQ-017 stIdle: Enable_i=0 -> stDisabled (priority); else timer==0 -> MeasureFSM_Start_o=1, go stXfer; else decrement timer.
REQ-018 stXfer on Done_i=1: add zero-extended sample to accumulator (width 2*DataWidth+AvgLog2, no overflow possible).
REQ-019 stXfer, Done_i=1 and counter < 2^AvgLog2-1: increment counter, assert MeasureFSM_Start_o the same cycle, stay stXfer (back-to-back burst).
REQ-020 stXfer, Done_i=1 on last sample: go stCompare; Enable_i is ignored in stXfer (burst always completes).
REQ-021 stCompare: mean = accumulator >> AvgLog2 (truncating); AbsDiff = |mean - SensorValue_o| computed without wrap.
REQ-022 stCompare: AbsDiff > ParamThreshold_i -> store mean into SensorValue_o, go stNotify; else go stIdle; always preset timer, clear accumulator and counter.
REQ-023 AbsDiff == ParamThreshold_i SHALL NOT notify.
REQ-024 stNotify: CpuIntr_o=1 for exactly one cycle, timer enabled, go stIdle.
REQ-025 ParamCounterPreset_i=0 -> stIdle leaves on its first cycle.
REQ-026 AvgLog2=0 -> single sample per cycle, mean = sample.
REQ-027 All outputs except SensorValue_o and Error_o SHALL be combinational state decodes with no further latency.

Reset
REQ-028 Reset SHALL force stDisabled, timer=0, accumulator=0, counter=0, SensorValue_o=0, Error_o=0, all pulse outputs 0.
REQ-029 Reset asserted mid-burst SHALL discard partial accumulation; no Start_o issued until re-enabled.

Configuration
REQ-030 Macro SENSOR_AVG_FSM_TIMEOUT_EN defined: a 2*DataWidth watchdog loads ParamCounterPreset_i at every Start_o, decrements in stXfer; reaching 0 without Done_i -> set Error_o, clear accumulator/counter, preset timer, go stIdle.
REQ-031 Macro undefined: no watchdog logic, Error_o tied 0, stXfer waits indefinitely.
REQ-032 Error_o SHALL clear only on reset or on stDisabled.

Structure
REQ-033 State encoding localparams SHALL live in package sensor_avg_fsm_pkg.
REQ-034 Idle timer (preset/enable/zero-flag) SHALL be sub-module sensor_timer, reused for the watchdog.

Verification
REQ-035 DW=8, AvgLog2=2, preset=3, thr=10, samples 100,104,108,112 -> mean 106, IntrPulse, SensorValue_o=106.
REQ-036 Next burst samples 110,112,114,116 -> mean 113, diff 7 <= 10, no interrupt, value stays 106.
REQ-037 Stored 106, mean 96 (diff exactly 10) -> no interrupt; mean 95 -> interrupt, value 95.
REQ-038 Enable_i dropped after 2nd Done -> burst finishes 4 samples, compares, then stDisabled from stIdle.
REQ-039 Reset pulse after 3rd Done -> all outputs 0; re-enable gives fresh 4-sample burst.
REQ-040 TIMEOUT_EN, preset=5, Done withheld -> Error_o=1 after 5 stXfer cycles, stIdle, Start_o reissued after timer expiry.

Source files
------------

// File: rtl/sensor_avg_fsm_pkg.sv
// sensor_avg_fsm_pkg
//   Shared definitions for the sensor averaging controller: state encodings
//   and the FSM state type.
//   Optional feature macro used by the controller: SENSOR_AVG_FSM_TIMEOUT_EN.
package sensor_avg_fsm_pkg;

  localparam logic [2:0] StDisabledEnc = 3'd0;
  localparam logic [2:0] StIdleEnc     = 3'd1;
  localparam logic [2:0] StXferEnc     = 3'd2;
  localparam logic [2:0] StCompareEnc  = 3'd3;
  localparam logic [2:0] StNotifyEnc   = 3'd4;

  typedef enum logic [2:0] {
    stDisabled = StDisabledEnc,
    stIdle     = StIdleEnc,
    stXfer     = StXferEnc,
    stCompare  = StCompareEnc,
    stNotify   = StNotifyEnc
  } state_t;

endpackage

// File: rtl/sensor_avg_fsm_if.sv
// sensor_avg_fsm_if
//   Handshake between the averaging controller and the measurement FSM.
//   Ports:
//     MeasureFSM_Start_o  one-cycle start request (controller -> measurement)
//     MeasureFSM_Done_i   measurement complete (measurement -> controller)
//     MeasureFSM_Byte0_i  sample low byte, valid with Done
//     MeasureFSM_Byte1_i  sample high byte, valid with Done
//   Modports: master = controller side, slave = measurement FSM side.
interface sensor_avg_fsm_if #(
  parameter int DataWidth = 8
);

  logic                 MeasureFSM_Start_o;
  logic                 MeasureFSM_Done_i;
  logic [DataWidth-1:0] MeasureFSM_Byte0_i;
  logic [DataWidth-1:0] MeasureFSM_Byte1_i;

  modport master (
    output MeasureFSM_Start_o,
    input  MeasureFSM_Done_i,
    input  MeasureFSM_Byte0_i,
    input  MeasureFSM_Byte1_i
  );

  modport slave (
    input  MeasureFSM_Start_o,
    output MeasureFSM_Done_i,
    output MeasureFSM_Byte0_i,
    output MeasureFSM_Byte1_i
  );

endinterface

// File: rtl/sensor_avg_fsm_timer.sv
// sensor_timer
//   Loadable down-counter with terminal-count (zero) flag. Used both as the
//   idle interval timer and as the measurement watchdog.
//   Ports:
//     Clk_i      clock, rising edge
//     Reset_n_i  asynchronous active-low reset (count -> 0)
//     Load_i     load Preset_i (wins over Enable_i)
//     Enable_i   decrement by one; holds at zero
//     Preset_i   reload value
//     Zero_o     count == 0
module sensor_timer #(
  parameter int Width = 16
) (
  input  logic             Clk_i,
  input  logic             Reset_n_i,
  input  logic             Load_i,
  input  logic             Enable_i,
  input  logic [Width-1:0] Preset_i,
  output logic             Zero_o
);

  logic [Width-1:0] count;

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      count <= '0;
    end else if (Load_i) begin
      count <= Preset_i;
    end else if (Enable_i && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign Zero_o = (count == '0);

endmodule

// File: rtl/sensor_avg_fsm.sv
// sensor_avg_fsm
//   Periodically triggers a burst of 2^AvgLog2 measurements, averages them and
//   notifies the CPU when the mean moved by more than a threshold from the
//   last stored value.
//   Parameters:
//     DataWidth  width of one measurement byte (sample = 2*DataWidth bits)
//     AvgLog2    log2 of samples per burst, 0..4
//   Ports:
//     Clk_i, Reset_n_i       clock, asynchronous active-low reset
//     Enable_i               block enable
//     CpuIntr_o              one-cycle notification pulse
//     SensorValue_o          last stored mean
//     Busy_o                 burst or compare in progress
//     Error_o                sticky measurement timeout flag
//     ParamThreshold_i       notification threshold (strictly greater notifies)
//     ParamCounterPreset_i   idle interval / watchdog preset
//     measIf                 measurement FSM handshake (master side)
//   Build option: define SENSOR_AVG_FSM_TIMEOUT_EN to add the measurement
//   watchdog; without it Error_o is constant 0 and a burst waits forever.
//
//   state      | meaning
//   stDisabled | block off, waiting for Enable_i
//   stIdle     | idle timer running; start a burst at terminal count
//   stXfer     | collecting samples from the measurement FSM
//   stCompare  | mean vs stored value, decide on notification
//   stNotify   | one-cycle CPU interrupt
module sensor_avg_fsm
  import sensor_avg_fsm_pkg::*;
#(
  parameter int DataWidth = 8,
  parameter int AvgLog2   = 2
) (
  input  logic                   Clk_i,
  input  logic                   Reset_n_i,
  input  logic                   Enable_i,
  output logic                   CpuIntr_o,
  output logic [2*DataWidth-1:0] SensorValue_o,
  output logic                   Busy_o,
  output logic                   Error_o,
  input  logic [2*DataWidth-1:0] ParamThreshold_i,
  input  logic [2*DataWidth-1:0] ParamCounterPreset_i,
  sensor_avg_fsm_if.master       measIf
);

  localparam int SampleW = 2 * DataWidth;
  localparam int AccW    = SampleW + AvgLog2;
  localparam int CntW    = (AvgLog2 > 0) ? AvgLog2 : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'((1 << AvgLog2) - 1);

  state_t              state;
  logic [AccW-1:0]     acc;
  logic [CntW-1:0]     sampleCnt;
  logic [SampleW-1:0]  sample;
  logic [SampleW-1:0]  mean;
  logic [SampleW-1:0]  absDiff;
  logic                doneSeen;
  logic                lastSample;
  logic                timeout;
  logic                idleZero;
  logic                idleLoad;
  logic                idleDec;

  assign sample     = {measIf.MeasureFSM_Byte1_i, measIf.MeasureFSM_Byte0_i};
  assign doneSeen   = (state == stXfer) && measIf.MeasureFSM_Done_i;
  assign lastSample = (sampleCnt == LastIdx);

  // Accumulator is wide enough for the whole burst, so the mean is a plain
  // truncating shift.
  assign mean    = SampleW'(acc >> AvgLog2);
  assign absDiff = (mean >= SensorValue_o) ? (mean - SensorValue_o)
                                           : (SensorValue_o - mean);

  // Outputs are direct decodes of the current state (plus Done in stXfer).
  assign measIf.MeasureFSM_Start_o = ((state == stIdle) && Enable_i && idleZero)
                                   || (doneSeen && !lastSample);
  assign CpuIntr_o = (state == stNotify);
  assign Busy_o    = (state == stXfer) || (state == stCompare);

  assign idleLoad = ((state == stDisabled) && Enable_i)
                  || (state == stCompare)
                  || timeout;
  assign idleDec  = ((state == stIdle) && Enable_i) || (state == stNotify);

  sensor_timer #(
    .Width (SampleW)
  ) uIdleTimer (
    .Clk_i     (Clk_i),
    .Reset_n_i (Reset_n_i),
    .Load_i    (idleLoad),
    .Enable_i  (idleDec),
    .Preset_i  (ParamCounterPreset_i),
    .Zero_o    (idleZero)
  );

`ifdef SENSOR_AVG_FSM_TIMEOUT_EN
  logic wdZero;
  logic wdDec;
  logic errorQ;

  // Reloaded on every start request, so each sample gets a full window.
  assign wdDec   = (state == stXfer) && !measIf.MeasureFSM_Done_i;
  assign timeout = wdDec && wdZero;

  sensor_timer #(
    .Width (SampleW)
  ) uWatchdog (
    .Clk_i     (Clk_i),
    .Reset_n_i (Reset_n_i),
    .Load_i    (measIf.MeasureFSM_Start_o),
    .Enable_i  (wdDec),
    .Preset_i  (ParamCounterPreset_i),
    .Zero_o    (wdZero)
  );

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      errorQ <= 1'b0;
    end else if (state == stDisabled) begin
      errorQ <= 1'b0;
    end else if (timeout) begin
      errorQ <= 1'b1;
    end
  end

  assign Error_o = errorQ;
`else
  assign timeout = 1'b0;
  assign Error_o = 1'b0;
`endif

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      state         <= stDisabled;
      acc           <= '0;
      sampleCnt     <= '0;
      SensorValue_o <= '0;
    end else begin
      case (state)
        stDisabled: begin
          if (Enable_i) begin
            acc       <= '0;
            sampleCnt <= '0;
            state     <= stIdle;
          end
        end

        stIdle: begin
          if (!Enable_i) begin
            state <= stDisabled;
          end else if (idleZero) begin
            state <= stXfer;
          end
        end

        // Enable_i is deliberately ignored here: a started burst completes.
        stXfer: begin
          if (measIf.MeasureFSM_Done_i) begin
            acc <= acc + AccW'(sample);
            if (lastSample) begin
              state <= stCompare;
            end else begin
              sampleCnt <= sampleCnt + 1'b1;
            end
          end else if (timeout) begin
            acc       <= '0;
            sampleCnt <= '0;
            state     <= stIdle;
          end
        end

        stCompare: begin
          if (absDiff > ParamThreshold_i) begin
            SensorValue_o <= mean;
            state         <= stNotify;
          end else begin
            state <= stIdle;
          end
          acc       <= '0;
          sampleCnt <= '0;
        end

        stNotify: begin
          state <= stIdle;
        end

        default: begin
          state <= stDisabled;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_avg_fsm.sv
// tb_sensor_avg_fsm
//   Directed bursts against sensor_avg_fsm (DataWidth=8, AvgLog2=2).
//   Expected compare outcomes are queued before each burst; a monitor pops
//   one entry each time Busy_o falls and checks interrupt, stored value,
//   start-request count and error flag.
module tb_sensor_avg_fsm;

  logic        Clk_i;
  logic        Reset_n_i;
  logic        Enable_i;
  logic        CpuIntr_o;
  logic [15:0] SensorValue_o;
  logic        Busy_o;
  logic        Error_o;
  logic [15:0] ParamThreshold_i;
  logic [15:0] ParamCounterPreset_i;

  sensor_avg_fsm_if #(.DataWidth(8)) measIf ();

  sensor_avg_fsm #(
    .DataWidth (8),
    .AvgLog2   (2)
  ) dut (
    .Clk_i                (Clk_i),
    .Reset_n_i            (Reset_n_i),
    .Enable_i             (Enable_i),
    .CpuIntr_o            (CpuIntr_o),
    .SensorValue_o        (SensorValue_o),
    .Busy_o               (Busy_o),
    .Error_o              (Error_o),
    .ParamThreshold_i     (ParamThreshold_i),
    .ParamCounterPreset_i (ParamCounterPreset_i),
    .measIf               (measIf)
  );

  typedef struct {
    bit          intr;
    logic [15:0] val;
    int          starts;
    bit          err;
  } exp_t;

  exp_t sbQ[$];
  int   checks = 0;
  int   errors = 0;

  initial begin
    Clk_i = 1'b0;
    forever #5 Clk_i = ~Clk_i;
  end

  initial begin
    #500000;
    $display("FAIL globalTimeout: simulation still running at %0t", $time);
    $fatal(1, "global time limit reached");
  end

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expectBurst(input bit intr, input int val, input int starts, input bit err);
    exp_t e;
    e.intr   = intr;
    e.val    = 16'(val);
    e.starts = starts;
    e.err    = err;
    sbQ.push_back(e);
  endtask

  // Monitor: one scoreboard entry per completed burst (Busy_o falling).
  initial begin
    bit   prevBusy;
    int   startCnt;
    bit   busyFall;
    exp_t e;
    prevBusy = 1'b0;
    startCnt = 0;
    forever begin
      @(negedge Clk_i);
      if (!Reset_n_i) begin
        prevBusy = 1'b0;
        startCnt = 0;
      end else begin
        busyFall = prevBusy && !Busy_o;
        if (busyFall) begin
          if (sbQ.size() == 0) begin
            cmp("sbUnexpectedCompletion", 1, 0);
          end else begin
            e = sbQ.pop_front();
            cmp("sbIntr", int'(CpuIntr_o), int'(e.intr));
            cmp("sbValue", int'(SensorValue_o), int'(e.val));
            cmp("sbStarts", startCnt, e.starts);
            cmp("sbError", int'(Error_o), int'(e.err));
          end
          startCnt = 0;
        end
        if (CpuIntr_o) cmp("intrOnlyAfterCompare", int'(busyFall), 1);
        if (measIf.MeasureFSM_Start_o) startCnt++;
        prevBusy = Busy_o;
      end
    end
  end

  task automatic waitStart(output bit ok, output int gap);
    int n;
    ok  = 1'b0;
    gap = 0;
    n   = 0;
    while (!ok && n < 200) begin
      @(negedge Clk_i);
      n++;
      if (measIf.MeasureFSM_Start_o) begin
        ok  = 1'b1;
        gap = n;
      end
    end
  endtask

  // Waits for a start request, then answers four measurements. Odd samples
  // arrive after 'lat' extra cycles, even ones back-to-back. Enable_i drops
  // after Done number dropAfter; reset asserts after Done number rstAfter.
  task automatic doBurst(input logic [15:0] s0, input logic [15:0] s1,
                         input logic [15:0] s2, input logic [15:0] s3,
                         input int lat, input int dropAfter, input int rstAfter,
                         output int gap);
    logic [15:0] smp [4];
    bit ok;
    bit stop;
    smp[0] = s0;
    smp[1] = s1;
    smp[2] = s2;
    smp[3] = s3;
    waitStart(ok, gap);
    cmp("startIssued", int'(ok), 1);
    if (ok) begin
      @(posedge Clk_i); #1;
      stop = 1'b0;
      for (int i = 0; i < 4 && !stop; i++) begin
        if (i % 2 == 1) repeat (lat) begin @(posedge Clk_i); #1; end
        measIf.MeasureFSM_Done_i  = 1'b1;
        measIf.MeasureFSM_Byte0_i = smp[i][7:0];
        measIf.MeasureFSM_Byte1_i = smp[i][15:8];
        @(posedge Clk_i); #1;
        measIf.MeasureFSM_Done_i  = 1'b0;
        measIf.MeasureFSM_Byte0_i = 8'h5A;
        measIf.MeasureFSM_Byte1_i = 8'hA5;
        if (i + 1 == dropAfter) Enable_i = 1'b0;
        if (i + 1 == rstAfter) begin
          Reset_n_i = 1'b0;
          stop      = 1'b1;
        end
      end
    end
  endtask

  task automatic checkAllZero(input string tag);
    cmp({tag, "_SensorValue"}, int'(SensorValue_o), 0);
    cmp({tag, "_CpuIntr"}, int'(CpuIntr_o), 0);
    cmp({tag, "_Busy"}, int'(Busy_o), 0);
    cmp({tag, "_Start"}, int'(measIf.MeasureFSM_Start_o), 0);
    cmp({tag, "_Error"}, int'(Error_o), 0);
  endtask

  initial begin
    int gap;
    int nStart;
    Reset_n_i                 = 1'b0;
    Enable_i                  = 1'b0;
    ParamThreshold_i          = 16'd10;
    ParamCounterPreset_i      = 16'd3;
    measIf.MeasureFSM_Done_i  = 1'b0;
    measIf.MeasureFSM_Byte0_i = 8'h00;
    measIf.MeasureFSM_Byte1_i = 8'h00;

    repeat (3) @(negedge Clk_i);
    checkAllZero("reset");
    @(posedge Clk_i); #1;
    Reset_n_i = 1'b1;
    repeat (2) @(negedge Clk_i);
    checkAllZero("disabledAfterReset");

    @(posedge Clk_i); #1;
    Enable_i = 1'b1;

    // First burst: mean 106, far from 0 -> notify.
    expectBurst(1, 106, 4, 0);
    doBurst(16'd100, 16'd104, 16'd108, 16'd112, 1, 0, 0, gap);

    // Mean 113, diff 7 -> quiet.
    expectBurst(0, 106, 4, 0);
    doBurst(16'd110, 16'd112, 16'd114, 16'd116, 1, 0, 0, gap);
    cmp("idleGapAfterNotify", gap, 5);

    // Mean 96, diff exactly 10 -> quiet.
    expectBurst(0, 106, 4, 0);
    doBurst(16'd95, 16'd96, 16'd97, 16'd96, 1, 0, 0, gap);
    cmp("idleGapAfterQuiet", gap, 5);

    // Mean 95 (382/4 truncated), diff 11 -> notify.
    expectBurst(1, 95, 4, 0);
    doBurst(16'd94, 16'd95, 16'd96, 16'd97, 1, 0, 0, gap);
    cmp("idleGapAfterQuiet2", gap, 5);

    // Samples using the high byte: mean 1001 (4006/4 truncated).
    expectBurst(1, 1001, 4, 0);
    doBurst(16'd1000, 16'd1001, 16'd1002, 16'd1003, 1, 0, 0, gap);
    cmp("idleGapBeforeHighByte", gap, 5);

    // Enable drops after 2nd Done: burst still completes, then disabled.
    expectBurst(0, 1001, 4, 0);
    doBurst(16'd1000, 16'd1000, 16'd1000, 16'd1004, 1, 2, 0, gap);
    cmp("idleGapBeforeDrop", gap, 5);
    nStart = 0;
    repeat (20) begin
      @(negedge Clk_i);
      if (measIf.MeasureFSM_Start_o) nStart++;
    end
    cmp("noStartWhileDisabled", nStart, 0);
    cmp("notBusyWhileDisabled", int'(Busy_o), 0);

    // Re-enable, reset after 3rd Done: partial burst discarded.
    @(posedge Clk_i); #1;
    Enable_i = 1'b1;
    doBurst(16'd500, 16'd500, 16'd500, 16'd500, 1, 0, 3, gap);
    repeat (2) @(negedge Clk_i);
    checkAllZero("midBurstReset");
    @(posedge Clk_i); #1;
    Reset_n_i = 1'b1;

    // Fresh burst: mean 41 vs stored 0 -> notify.
    expectBurst(1, 41, 4, 0);
    doBurst(16'd40, 16'd40, 16'd40, 16'd44, 1, 0, 0, gap);
    // Takes effect at this burst's compare.
    ParamCounterPreset_i = 16'd0;

    expectBurst(0, 41, 4, 0);
    doBurst(16'd41, 16'd41, 16'd41, 16'd41, 0, 0, 0, gap);
    cmp("idleGapPreset0Notify", gap, 3);

    expectBurst(1, 61, 4, 0);
    doBurst(16'd60, 16'd61, 16'd62, 16'd63, 0, 0, 0, gap);
    cmp("idleGapPreset0Quiet", gap, 2);

    // Mean 71 (286/4 truncated), diff exactly 10 -> quiet.
    expectBurst(0, 61, 4, 0);
    doBurst(16'd70, 16'd71, 16'd72, 16'd73, 0, 0, 0, gap);
    cmp("idleGapPreset0Notify2", gap, 3);

`ifdef SENSOR_AVG_FSM_TIMEOUT_EN
    begin
      bit ok;
      int n;
      ParamCounterPreset_i = 16'd5;
      expectBurst(0, 61, 1, 1);
      waitStart(ok, gap);
      cmp("timeoutStartIssued", int'(ok), 1);
      n = 0;
      while (!Error_o && n < 20) begin
        @(negedge Clk_i);
        n++;
      end
      cmp("timeoutErrorSet", int'(Error_o), 1);
      waitStart(ok, gap);
      cmp("timeoutStartReissued", int'(ok), 1);
    end
`endif

    repeat (5) @(negedge Clk_i);
    cmp("sbDrained", sbQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
